quantum_scheduler: RTL and testbench
====================================

QUANTUM_SCHEDULER -- requirements
Module: quantum_scheduler

Interface
REQ-001 SHALL have parameter NPROG, default 8: number of program slots, power of two.
REQ-002 SHALL have parameter QW, default 16: quantum and counter width.
REQ-003 SHALL have parameter QUANTUM_RESET, default 100: quantum value after reset.
REQ-004 SHALL have port clock  in  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1: reset is synchronous and active-high.
REQ-006 SHALL have port defquantum  in  1: load quantum_in into the quantum register.
REQ-007 SHALL have port quantum_in  in  QW: new quantum value.
REQ-008 SHALL have port load_slot  in  1: mark slot slot_in valid.
REQ-009 SHALL have port slot_in  in  log2(NPROG): slot index for load_slot/changeProgram.
REQ-010 SHALL have port changeProgram  in  1: kernel dispatch of slot slot_in.
REQ-011 SHALL have port nextProgram  in  1: kernel dispatch of next_program.
REQ-012 SHALL have port endProgram  in  1: running program halted.
REQ-013 SHALL have port stop  in  1: processor stalled on I/O; counter freezes.
REQ-014 SHALL have port preempt_ack  in  1: kernel accepted preemption.
REQ-015 SHALL have port running  out  1: user program executing (state USER).
REQ-016 SHALL have port preempt  out  1: quantum expired, level until acked.
REQ-017 SHALL have port current_program  out  log2(NPROG): active/last dispatched slot.
REQ-018 SHALL have port next_program  out  log2(NPROG): round-robin candidate.
REQ-019 SHALL have port no_program  out  1: no valid slot.
REQ-020 SHALL have port quantum_left  out  QW: remaining cycles in slice.
REQ-021 SHALL have port dispatch_err  out  1: one-cycle pulse on dispatch of invalid slot.

Function
REQ-022 SHALL implement states KERNEL, USER, PREEMPT; running=1 only in USER, preempt=1 only in PREEMPT.
REQ-023 SHALL keep valid[NPROG-1:0]; no_program = NOR of valid, combinational.
REQ-024 SHALL compute next_program combinationally: first valid slot searching current_program+1 upward with wrap, current_program itself checked last; equals current_program when no_program.
REQ-025 KERNEL: changeProgram with valid[slot_in] -> USER, current_program=slot_in, quantum_left=quantum, next cycle.
REQ-026 KERNEL: changeProgram with invalid slot -> stay KERNEL, dispatch_err=1 for one cycle, current_program unchanged.
REQ-027 KERNEL: nextProgram with !no_program -> USER, current_program=next_program, quantum_left=quantum; with no_program -> stay, dispatch_err pulse.
REQ-028 KERNEL: changeProgram has priority over simultaneous nextProgram.
REQ-029 USER: quantum_left decrements by 1 each cycle with stop=0; holds while stop=1.
REQ-030 USER: when quantum_left==1 and stop=0, next state PREEMPT, quantum_left becomes 0.
REQ-031 USER: quantum==0 at dispatch means unlimited slice: no decrement, no preemption.
REQ-032 USER: endProgram -> KERNEL, valid[current_program] cleared; priority over same-cycle expiry.
REQ-033 USER/PREEMPT: changeProgram and nextProgram ignored.
REQ-034 PREEMPT: preempt_ack -> KERNEL, valid unchanged; endProgram -> KERNEL with valid clear, priority over ack.
REQ-035 KERNEL: endProgram, preempt_ack, stop ignored; quantum_left holds.
REQ-036 defquantum in any state updates quantum register; running slice unaffected, used at next dispatch.
REQ-037 load_slot in any state sets valid[slot_in]; same-cycle endProgram clearing the same slot: set wins.
REQ-038 All outputs registered except next_program and no_program.

Reset
REQ-039 reset SHALL set state KERNEL, valid=0, current_program=0, quantum=QUANTUM_RESET, quantum_left=0, dispatch_err=0.
REQ-040 reset mid-slice or in PREEMPT SHALL abandon the slice immediately; reset overrides every other input.

Verification
REQ-041 Reset; load_slot 0,2,5; nextProgram -> current_program=2 (search from 1), running=1, quantum_left=100.
REQ-042 defquantum quantum_in=3; dispatch slot 5 -> USER 3 cycles (3,2,1), then preempt=1, quantum_left=0; preempt_ack -> KERNEL; nextProgram -> slot 0 (wrap).
REQ-043 quantum=4, stop high 2 cycles mid-slice -> preempt asserts 6 cycles after dispatch.
REQ-044 endProgram same cycle quantum_left==1 -> KERNEL, preempt never asserts, valid[current] cleared.
REQ-045 changeProgram slot 7 (invalid) -> dispatch_err one cycle, stays KERNEL; all slots ended -> no_program=1, nextProgram -> dispatch_err.
REQ-046 quantum=0 dispatch, run 1000 cycles -> no preempt; reset mid-slice -> KERNEL, valid=0, quantum=100.

Source files
------------

// File: rtl/quantum_scheduler.sv
// Round-robin time-slice scheduler: tracks valid program slots, dispatches
// them on kernel request and preempts the running program when its quantum
// expires.
module quantum_scheduler #(
    parameter int unsigned NPROG         = 8,
    parameter int unsigned QW            = 16,
    parameter int unsigned QUANTUM_RESET = 100
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       defquantum,
    input  logic [QW-1:0]              quantum_in,
    input  logic                       load_slot,
    input  logic [$clog2(NPROG)-1:0]   slot_in,
    input  logic                       changeProgram,
    input  logic                       nextProgram,
    input  logic                       endProgram,
    input  logic                       stop,
    input  logic                       preempt_ack,
    output logic                       running,
    output logic                       preempt,
    output logic [$clog2(NPROG)-1:0]   current_program,
    output logic [$clog2(NPROG)-1:0]   next_program,
    output logic                       no_program,
    output logic [QW-1:0]              quantum_left,
    output logic                       dispatch_err
);

    localparam int unsigned SW = $clog2(NPROG);

    typedef enum logic [1:0] {
        KERNEL  = 2'd0,
        USER    = 2'd1,
        PREEMPT = 2'd2
    } state_t;

    state_t          state;
    logic [NPROG-1:0] valid;
    logic [NPROG-1:0] valid_next;
    logic [QW-1:0]   quantum;
    logic            unlimited;
    logic [SW-1:0]   probe;
    logic            end_clear;

    // Empty-slot indicator straight from the valid vector.
    assign no_program = ~|valid;

    // A halted program frees its slot only while it actually owns the CPU.
    assign end_clear = endProgram && (state != KERNEL);

    // Round-robin candidate: nearest valid slot above current, current last.
    always_comb begin
        next_program = current_program;
        probe        = current_program;
        for (int i = int'(NPROG); i > 0; i--) begin
            probe = current_program + SW'(i);
            if (valid[probe]) begin
                next_program = probe;
            end
        end
    end

    // Slot bookkeeping: clear on halt, then a same-cycle load re-sets the slot.
    always_comb begin
        valid_next = valid;
        if (end_clear) begin
            valid_next[current_program] = 1'b0;
        end
        if (load_slot) begin
            valid_next[slot_in] = 1'b1;
        end
    end

    // Scheduler state machine with its registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= KERNEL;
            valid           <= '0;
            current_program <= '0;
            quantum         <= QW'(QUANTUM_RESET);
            quantum_left    <= '0;
            unlimited       <= 1'b0;
            running         <= 1'b0;
            preempt         <= 1'b0;
            dispatch_err    <= 1'b0;
        end else begin
            valid        <= valid_next;
            dispatch_err <= 1'b0;
            if (defquantum) begin
                quantum <= quantum_in;
            end
            case (state)
                KERNEL: begin
                    if (changeProgram) begin
                        if (valid[slot_in]) begin
                            state           <= USER;
                            running         <= 1'b1;
                            current_program <= slot_in;
                            quantum_left    <= quantum;
                            unlimited       <= (quantum == '0);
                        end else begin
                            dispatch_err <= 1'b1;
                        end
                    end else if (nextProgram) begin
                        if (!no_program) begin
                            state           <= USER;
                            running         <= 1'b1;
                            current_program <= next_program;
                            quantum_left    <= quantum;
                            unlimited       <= (quantum == '0);
                        end else begin
                            dispatch_err <= 1'b1;
                        end
                    end
                end
                USER: begin
                    if (endProgram) begin
                        state   <= KERNEL;
                        running <= 1'b0;
                    end else if (!unlimited && !stop) begin
                        quantum_left <= quantum_left - QW'(1);
                        if (quantum_left == QW'(1)) begin
                            state   <= PREEMPT;
                            running <= 1'b0;
                            preempt <= 1'b1;
                        end
                    end
                end
                PREEMPT: begin
                    if (endProgram || preempt_ack) begin
                        state   <= KERNEL;
                        preempt <= 1'b0;
                    end
                end
                default: begin
                    state   <= KERNEL;
                    running <= 1'b0;
                    preempt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quantum_scheduler.sv
// Self-checking bench for quantum_scheduler: directed scenarios against
// hand-derived values plus randomized traffic against a behavioural model.
module tb_quantum_scheduler;

    localparam int NPROG = 8;
    localparam int QW    = 16;
    localparam int SW    = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          defquantum;
    logic [QW-1:0] quantum_in;
    logic          load_slot;
    logic [SW-1:0] slot_in;
    logic          changeProgram;
    logic          nextProgram;
    logic          endProgram;
    logic          stop;
    logic          preempt_ack;
    logic          running;
    logic          preempt;
    logic [SW-1:0] current_program;
    logic [SW-1:0] next_program;
    logic          no_program;
    logic [QW-1:0] quantum_left;
    logic          dispatch_err;

    int errors = 0;
    int checks = 0;

    // Behavioural model: 0=kernel, 1=user, 2=preempt.
    int m_mode;
    bit m_valid[NPROG];
    int m_cur;
    int m_q;
    int m_ql;
    bit m_unl;
    bit m_err;

    quantum_scheduler #(.NPROG(NPROG), .QW(QW), .QUANTUM_RESET(100)) dut (
        .clock(clock), .reset(reset), .defquantum(defquantum),
        .quantum_in(quantum_in), .load_slot(load_slot), .slot_in(slot_in),
        .changeProgram(changeProgram), .nextProgram(nextProgram),
        .endProgram(endProgram), .stop(stop), .preempt_ack(preempt_ack),
        .running(running), .preempt(preempt),
        .current_program(current_program), .next_program(next_program),
        .no_program(no_program), .quantum_left(quantum_left),
        .dispatch_err(dispatch_err)
    );

    always #5 clock = ~clock;

    function automatic bit m_any();
        for (int k = 0; k < NPROG; k++) if (m_valid[k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_search();
        for (int k = 1; k <= NPROG; k++) begin
            if (m_valid[(m_cur + k) % NPROG]) return (m_cur + k) % NPROG;
        end
        return m_cur;
    endfunction

    task automatic m_dispatch(input int slot);
        m_mode = 1;
        m_cur  = slot;
        m_ql   = m_q;
        m_unl  = (m_q == 0);
    endtask

    task automatic step_model();
        if (reset) begin
            m_mode = 0;
            for (int k = 0; k < NPROG; k++) m_valid[k] = 1'b0;
            m_cur = 0; m_q = 100; m_ql = 0; m_unl = 1'b0; m_err = 1'b0;
            return;
        end
        m_err = 1'b0;
        if (m_mode == 0) begin
            if (changeProgram) begin
                if (m_valid[slot_in]) m_dispatch(int'(slot_in));
                else m_err = 1'b1;
            end else if (nextProgram) begin
                if (m_any()) m_dispatch(m_search());
                else m_err = 1'b1;
            end
        end else if (m_mode == 1) begin
            if (endProgram) begin
                m_valid[m_cur] = 1'b0;
                m_mode = 0;
            end else if (!m_unl && !stop) begin
                m_ql = m_ql - 1;
                if (m_ql == 0) m_mode = 2;
            end
        end else begin
            if (endProgram) begin
                m_valid[m_cur] = 1'b0;
                m_mode = 0;
            end else if (preempt_ack) begin
                m_mode = 0;
            end
        end
        if (load_slot) m_valid[slot_in] = 1'b1;
        if (defquantum) m_q = int'(quantum_in);
    endtask

    task automatic tick();
        @(posedge clock);
        step_model();
        #1;
    endtask

    task automatic idle();
        reset = 0; defquantum = 0; quantum_in = '0; load_slot = 0; slot_in = '0;
        changeProgram = 0; nextProgram = 0; endProgram = 0; stop = 0; preempt_ack = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic load(input int s);
        load_slot = 1; slot_in = SW'(s);
        tick();
        load_slot = 0;
    endtask

    task automatic set_quantum(input int q);
        defquantum = 1; quantum_in = QW'(q);
        tick();
        defquantum = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1; changeProgram = 1; load_slot = 1; slot_in = 3; defquantum = 1; quantum_in = 7;
        tick();
        tick();
        idle();
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%0b want=0", running); end
        checks++; if (preempt !== 1'b0) begin errors++; $display("FAIL reset_preempt got=%0b want=0", preempt); end
        checks++; if (current_program !== 3'd0) begin errors++; $display("FAIL reset_current got=%0d want=0", current_program); end
        checks++; if (quantum_left !== 16'd0) begin errors++; $display("FAIL reset_quantum_left got=%0d want=0", quantum_left); end
        checks++; if (dispatch_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b want=0", dispatch_err); end
        checks++; if (no_program !== 1'b1) begin errors++; $display("FAIL reset_no_program got=%0b want=1", no_program); end
    endtask

    task automatic test_dispatch_search();
        do_reset();
        load(0); load(2); load(5);
        checks++; if (next_program !== 3'd2) begin errors++; $display("FAIL search_candidate got=%0d want=2", next_program); end
        nextProgram = 1;
        tick();
        nextProgram = 0;
        checks++; if (current_program !== 3'd2) begin errors++; $display("FAIL search_current got=%0d want=2", current_program); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL search_running got=%0b want=1", running); end
        checks++; if (quantum_left !== 16'd100) begin errors++; $display("FAIL search_quantum_left got=%0d want=100", quantum_left); end
    endtask

    task automatic test_preempt_wrap();
        set_quantum(3);
        checks++; if (quantum_left !== 16'd99) begin errors++; $display("FAIL slice_unaffected got=%0d want=99", quantum_left); end
        endProgram = 1;
        tick();
        endProgram = 0;
        changeProgram = 1; slot_in = 5;
        tick();
        changeProgram = 0;
        for (int k = 3; k >= 1; k--) begin
            checks++; if (running !== 1'b1 || quantum_left !== QW'(k)) begin
                errors++; $display("FAIL slice_count running=%0b got=%0d want=%0d", running, quantum_left, k);
            end
            tick();
        end
        checks++; if (preempt !== 1'b1 || running !== 1'b0 || quantum_left !== 16'd0) begin
            errors++; $display("FAIL expiry preempt=%0b running=%0b ql=%0d want 1/0/0", preempt, running, quantum_left);
        end
        changeProgram = 1; slot_in = 0;
        tick();
        changeProgram = 0;
        checks++; if (preempt !== 1'b1 || current_program !== 3'd5) begin
            errors++; $display("FAIL preempt_ignores_dispatch preempt=%0b cur=%0d want 1/5", preempt, current_program);
        end
        preempt_ack = 1;
        tick();
        preempt_ack = 0;
        checks++; if (preempt !== 1'b0 || running !== 1'b0) begin
            errors++; $display("FAIL ack preempt=%0b running=%0b want 0/0", preempt, running);
        end
        nextProgram = 1;
        tick();
        nextProgram = 0;
        checks++; if (current_program !== 3'd0 || quantum_left !== 16'd3) begin
            errors++; $display("FAIL wrap cur=%0d ql=%0d want 0/3", current_program, quantum_left);
        end
    endtask

    task automatic test_stop();
        int n;
        do_reset();
        load(1);
        set_quantum(4);
        changeProgram = 1; slot_in = 1;
        tick();
        changeProgram = 0;
        n = 0;
        while (preempt !== 1'b1 && n < 20) begin
            stop = (n == 1 || n == 2);
            tick();
            n++;
        end
        stop = 0;
        checks++; if (n !== 6) begin errors++; $display("FAIL stop_latency got=%0d want=6", n); end
    endtask

    task automatic test_end_expiry();
        bit seen;
        do_reset();
        load(3);
        set_quantum(2);
        changeProgram = 1; slot_in = 3;
        tick();
        changeProgram = 0;
        tick();
        checks++; if (quantum_left !== 16'd1) begin errors++; $display("FAIL end_setup got=%0d want=1", quantum_left); end
        endProgram = 1;
        tick();
        endProgram = 0;
        seen = preempt;
        for (int k = 0; k < 4; k++) begin tick(); seen |= preempt; end
        checks++; if (seen !== 1'b0 || running !== 1'b0) begin
            errors++; $display("FAIL end_priority preempt_seen=%0b running=%0b want 0/0", seen, running);
        end
        checks++; if (no_program !== 1'b1) begin errors++; $display("FAIL end_clear got=%0b want=1", no_program); end
    endtask

    task automatic test_errors();
        do_reset();
        load(0); load(1);
        changeProgram = 1; slot_in = 7;
        tick();
        changeProgram = 0;
        checks++; if (dispatch_err !== 1'b1 || running !== 1'b0 || current_program !== 3'd0) begin
            errors++; $display("FAIL bad_slot err=%0b running=%0b cur=%0d want 1/0/0", dispatch_err, running, current_program);
        end
        tick();
        checks++; if (dispatch_err !== 1'b0) begin errors++; $display("FAIL err_pulse got=%0b want=0", dispatch_err); end
        changeProgram = 1; nextProgram = 1; slot_in = 0;
        tick();
        changeProgram = 0; nextProgram = 0;
        checks++; if (current_program !== 3'd0 || running !== 1'b1) begin
            errors++; $display("FAIL change_priority cur=%0d running=%0b want 0/1", current_program, running);
        end
        endProgram = 1; load_slot = 1; slot_in = 0;
        tick();
        endProgram = 0; load_slot = 0;
        checks++; if (next_program !== 3'd1 || no_program !== 1'b0) begin
            errors++; $display("FAIL set_wins next=%0d nop=%0b want 1/0", next_program, no_program);
        end
        changeProgram = 1; slot_in = 0;
        tick();
        changeProgram = 0;
        endProgram = 1; tick(); endProgram = 0;
        nextProgram = 1; tick(); nextProgram = 0;
        checks++; if (current_program !== 3'd1) begin errors++; $display("FAIL next_after_end got=%0d want=1", current_program); end
        endProgram = 1; tick(); endProgram = 0;
        checks++; if (no_program !== 1'b1 || next_program !== 3'd1) begin
            errors++; $display("FAIL all_ended nop=%0b next=%0d want 1/1", no_program, next_program);
        end
        nextProgram = 1; tick(); nextProgram = 0;
        checks++; if (dispatch_err !== 1'b1 || running !== 1'b0) begin
            errors++; $display("FAIL empty_next err=%0b running=%0b want 1/0", dispatch_err, running);
        end
    endtask

    task automatic test_unlimited_reset();
        bit seen;
        do_reset();
        load(4);
        set_quantum(0);
        changeProgram = 1; slot_in = 4;
        tick();
        changeProgram = 0;
        seen = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            stop = ($urandom_range(0, 3) == 0);
            tick();
            seen |= preempt | ~running;
        end
        stop = 0;
        checks++; if (seen !== 1'b0 || quantum_left !== 16'd0) begin
            errors++; $display("FAIL unlimited seen=%0b ql=%0d want 0/0", seen, quantum_left);
        end
        reset = 1; tick(); reset = 0;
        checks++; if (running !== 1'b0 || no_program !== 1'b1 || current_program !== 3'd0) begin
            errors++; $display("FAIL mid_reset running=%0b nop=%0b cur=%0d want 0/1/0", running, no_program, current_program);
        end
        load(6);
        changeProgram = 1; slot_in = 6;
        tick();
        changeProgram = 0;
        checks++; if (quantum_left !== 16'd100) begin errors++; $display("FAIL reset_quantum got=%0d want=100", quantum_left); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 399) == 0);
            defquantum    = ($urandom_range(0, 19) == 0);
            quantum_in    = QW'($urandom_range(0, 6));
            load_slot     = ($urandom_range(0, 4) == 0);
            slot_in       = SW'($urandom_range(0, NPROG - 1));
            changeProgram = ($urandom_range(0, 9) == 0);
            nextProgram   = ($urandom_range(0, 9) == 0);
            endProgram    = ($urandom_range(0, 19) == 0);
            stop          = ($urandom_range(0, 4) == 0);
            preempt_ack   = ($urandom_range(0, 5) == 0);
            tick();
            checks++; if (running !== (m_mode == 1) || preempt !== (m_mode == 2)) begin
                errors++; $display("FAIL rand_state c=%0d running=%0b preempt=%0b want_mode=%0d", c, running, preempt, m_mode);
            end
            checks++; if (current_program !== SW'(m_cur)) begin
                errors++; $display("FAIL rand_current c=%0d got=%0d want=%0d", c, current_program, m_cur);
            end
            checks++; if (quantum_left !== QW'(m_ql)) begin
                errors++; $display("FAIL rand_quantum_left c=%0d got=%0d want=%0d", c, quantum_left, m_ql);
            end
            checks++; if (dispatch_err !== m_err) begin
                errors++; $display("FAIL rand_err c=%0d got=%0b want=%0b", c, dispatch_err, m_err);
            end
            checks++; if (no_program !== !m_any() || next_program !== SW'(m_search())) begin
                errors++; $display("FAIL rand_candidate c=%0d nop=%0b next=%0d want %0b/%0d", c, no_program, next_program, !m_any(), m_search());
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_dispatch_search();
        test_preempt_wrap();
        test_stop();
        test_end_expiry();
        test_errors();
        test_unlimited_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
